// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: ALU control codes, main-decoder ALU classes
// and default datapath widths.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REGW_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12,
    ALU_NOP = 4'd15
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_NOR    = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctl_decode.sv
// Second-level ALU decoder: maps the main-decoder ALU class plus funct bits onto
// the 4-bit ALU control code.
module alu_ctl_decode
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_src,
  output logic [3:0] alu_ctl
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    alu_ctl = ALU_NOP;
    case (alu_op)
      ALUOP_MEM:    alu_ctl = ALU_ADD;
      ALUOP_BRANCH: alu_ctl = ALU_SUB;
      ALUOP_NOR:    alu_ctl = ALU_NOR;
      ALUOP_RTYPE: begin
        case (funct3)
          // bit 30 only means SUB for register-register forms; for ADDI it is immediate
          F3_ADD:  alu_ctl = (funct7_5 && !alu_src) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_ctl = ALU_AND;
          F3_OR:   alu_ctl = ALU_OR;
          F3_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_NOP;
        endcase
      end
      default: alu_ctl = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the registered ALU: operand forwarding, ALU
// control decode and load-use bubble insertion.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int REGW = REGW_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [REGW-1:0] rd,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            alu_src,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [3:0]      ALUctl,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic            ex_valid,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } stage_t;

  stage_t stage_q, stage_d;
  logic [3:0]      dec_ctl;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // Newest producer wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic [REGW-1:0] em_rd,
    input logic            em_we,
    input logic [XLEN-1:0] em_res,
    input logic [REGW-1:0] wb_rd,
    input logic            wb_we,
    input logic [XLEN-1:0] wb_res
  );
    if (em_we && (em_rd != '0) && (em_rd == rs))      return em_res;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return wb_res;
    else                                              return rf_data;
  endfunction

  always_comb begin
    load_use_stall = 1'b0;
    if (!stall && !flush && in_valid && stage_q.valid && stage_q.mem_read &&
        (stage_q.rd != '0) &&
        ((stage_q.rd == rs1) || ((stage_q.rd == rs2) && (!alu_src || mem_write))))
      load_use_stall = 1'b1;
  end

  always_comb begin
    stage_d = stage_q;
    if (flush || (!stall && load_use_stall)) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
      stage_d.mem_write = 1'b0;
      stage_d.rd        = '0;
    end else if (!stall) begin
      stage_d.valid     = in_valid;
      stage_d.rs1_data  = rs1_data;
      stage_d.rs2_data  = rs2_data;
      stage_d.imm       = imm;
      stage_d.rs1       = rs1;
      stage_d.rs2       = rs2;
      stage_d.rd        = rd;
      stage_d.alu_op    = alu_op;
      stage_d.funct3    = funct3;
      stage_d.funct7_5  = funct7_5;
      stage_d.alu_src   = alu_src;
      stage_d.reg_write = reg_write;
      stage_d.mem_read  = mem_read;
      stage_d.mem_write = mem_write;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  alu_ctl_decode u_alu_ctl_decode (
    .alu_op   (stage_q.alu_op),
    .funct3   (stage_q.funct3),
    .funct7_5 (stage_q.funct7_5),
    .alu_src  (stage_q.alu_src),
    .alu_ctl  (dec_ctl)
  );

  always_comb begin
    rs1_fwd = fwd_sel(stage_q.rs1, stage_q.rs1_data, exmem_rd, exmem_reg_write, exmem_result,
                      memwb_rd, memwb_reg_write, memwb_result);
    rs2_fwd = fwd_sel(stage_q.rs2, stage_q.rs2_data, exmem_rd, exmem_reg_write, exmem_result,
                      memwb_rd, memwb_reg_write, memwb_result);
  end

  assign A             = rs1_fwd;
  assign B             = stage_q.alu_src ? stage_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ALUctl        = stage_q.valid ? dec_ctl : 4'(ALU_NOP);
  assign ex_valid      = stage_q.valid;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the registered RISC-V ALU. It latches decoded instruction fields and register-file operands, resolves forwarding from EX/MEM and MEM/WB, and decodes ALUOp/funct into the 4-bit ALU control code. It drives the ALU's `ALUctl`, `A` and `B` inputs. It detects load-use hazards and inserts bubbles.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `in_valid` in 1: ID holds a real instruction.
- `stall` in 1: external hold; freeze stage contents.
- `flush` in 1: kill the instruction being captured.
- `rs1_data`, `rs2_data` in XLEN: register-file read data.
- `imm` in XLEN: sign-extended immediate.
- `rs1`, `rs2`, `rd` in REGW: register indices.
- `alu_op` in 2: main-decoder ALU class.
- `funct3` in 3: instruction funct3.
- `funct7_5` in 1: instruction bit 30.
- `alu_src` in 1: 1 selects `imm` for B.
- `reg_write`, `mem_read`, `mem_write` in 1: control bits.
- `exmem_rd` in REGW, `exmem_reg_write` in 1, `exmem_result` in XLEN: EX/MEM forward source.
- `memwb_rd` in REGW, `memwb_reg_write` in 1, `memwb_result` in XLEN: MEM/WB forward source.
- `ALUctl` out 4: ALU operation code.
- `A`, `B` out XLEN: ALU operands.
- `ex_valid` out 1: stage holds a live instruction.
- `ex_rd` out REGW, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: forwarded control bits.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `load_use_stall` out 1: hazard request to IF/ID (hold PC and IF/ID).

## Operation
- The stage register is updated at each `CLK` edge. Priority, highest first:
  1. `RST`: `ex_valid`=0, all control bits 0, all fields 0.
  2. `flush`: bubble.
  3. `stall`: hold all contents.
  4. `load_use_stall`: bubble.
  5. Otherwise capture the ID inputs, with `ex_valid`=`in_valid`.
- A bubble is `ex_valid`=0 with `reg_write`, `mem_read` and `mem_write` cleared. Data fields are don't-care, but `rd` is cleared to 0.
- `load_use_stall` is combinational. It is 1 when all of the following hold:
  - `ex_valid` and `ex_mem_read` are set;
  - `ex_rd`≠0;
  - `ex_rd` equals `rs1`, or equals `rs2` with `alu_src`=0 or `mem_write`=1;
  - `in_valid` is set.
- `load_use_stall` is forced to 0 while `stall` or `flush` is high.
- Forwarding is combinational from the registered fields, applied per source (rs1→A, rs2→B-path and store data):
  - EX/MEM hit: `exmem_reg_write` && `exmem_rd`≠0 && `exmem_rd`==rsN. This source wins.
  - Otherwise MEM/WB hit, with the same condition on the memwb signals.
  - Otherwise the registered register-file data.
  - Register x0 is never forwarded.
- `B` is `imm` when the registered `alu_src`=1, otherwise the forwarded rs2. `ex_store_data` is always the forwarded rs2.
- `ALUctl` decode, from registered fields:
  - `alu_op`=00 → 2 (add).
  - `alu_op`=01 → 6 (sub, branch compare).
  - `alu_op`=10, `funct3`=000 → 6 if `funct7_5`=1 and `alu_src`=0, else 2.
  - `alu_op`=10, `funct3`=111 → 0. `funct3`=110 → 1. `funct3`=010 → 7.
  - `alu_op`=10, any other `funct3` → 15.
  - `alu_op`=11 → 12.
  - `ex_valid`=0 → 15, so the ALU produces 0.
- Arithmetic: none in this block; widths pass through unchanged.

## Timing
- Instruction captured at edge N drives `A`/`B`/`ALUctl` during cycle N. The ALU result is registered at edge N+1.
- End-to-end latency from ID to ALU result: 2 edges.
- Forwarding sources are sampled in the same cycle they are presented; there are no internal forward registers.
- Load-use:
  - The hazard asserts in the cycle the load occupies EX.
  - One bubble enters at the next edge; upstream holds ID.
  - The dependent instruction is captured one edge later, when MEM/WB forwarding supplies the load data.
- Reset values: `ex_valid`=0, `ex_rd`=0, `ex_reg_write`/`ex_mem_read`/`ex_mem_write`=0, `ALUctl`=15. `A`, `B`, `ex_store_data` are 0 unless forwarded. `load_use_stall`=0.
- `RST` asserted mid-stall or mid-hazard clears everything at that edge. `flush` together with `stall` produces a bubble.

## Structure
- Shared package `riscv_pkg`:
  - `ALUctl` constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, NOP=15.
  - `alu_op` encodings.
  - `XLEN`/`REGW` defaults.
- One sub-module, `alu_ctl_decode`: combinational `alu_op`/`funct3`/`funct7_5`/`alu_src` → `ALUctl`.

## Test plan
- `add x3,x1,x2` with rs1_data=5, rs2_data=7, no hazards → next cycle A=5, B=7, ALUctl=2, ex_valid=1.
- Register x1 with exmem_rd=1, exmem_result=0x10 and memwb_rd=1, memwb_result=0x20 → A=0x10. Repeat with exmem_rd=0 and rs1=0 → A=rs1_data, no forwarding.
- `lw x4` in EX, then `sub x5,x4,x6` in ID → load_use_stall=1 for one cycle. Next edge ex_valid=0, ALUctl=15. Following edge captures sub with ALUctl=6.
- `stall`=1 for 3 cycles with `addi` in the stage → A, B, ALUctl and ex_valid held constant. With `flush`=1 and `stall`=1 → bubble.
- `funct3`=111/110/010/001 with `alu_op`=10 → ALUctl=0/1/7/15. `alu_op`=11 → 12.
- `RST` asserted while load_use_stall=1 → next edge ex_valid=0, all control bits 0, load_use_stall=0.
